tri_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one TRI (L1.5) port among SOURCE_NUM requesters.
//  One outstanding transaction at a time; the scheduler watches the response and times it out.

---
 rtl/tri_rr_sched_pkg.sv | 39 +++
 rtl/tri_rr_sched_if.sv | 30 +++
 rtl/tri_rr_sched_rr_picker.sv | 39 +++
 rtl/tri_rr_sched.sv | 153 +++++++++++++++
 tb/tb_tri_rr_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_rr_sched_pkg.sv
// Shared types for the TRI round-robin scheduler: L1.5 request/response
// opcodes, the scheduler state encoding and the request->response mapping.
package tri_rr_sched_pkg;

    typedef enum logic [4:0] {
        LOAD_RQ  = 5'b00000,
        STORE_RQ = 5'b00001,
        CAS1_RQ  = 5'b00010,
        SWAP_RQ  = 5'b00110,
        INT_RQ   = 5'b01001,
        IMISS_RQ = 5'b10000
    } l15_reqtypes_t;

    typedef enum logic [3:0] {
        LOAD_RET  = 4'b0000,
        IFILL_RET = 4'b0001,
        INV_RET   = 4'b0011,
        ST_ACK    = 4'b0100,
        INT_RET   = 4'b0111
    } l15_rettypes_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // Response type that completes a granted request.
    function automatic l15_rettypes_t exp_resp_type(input l15_reqtypes_t t);
        return (t == STORE_RQ) ? ST_ACK : LOAD_RET;
    endfunction

    // Only plain loads and stores are carried to the sink.
    function automatic logic is_supported(input l15_reqtypes_t t);
        return (t == LOAD_RQ) || (t == STORE_RQ);
    endfunction

endpackage

// File: rtl/tri_rr_sched_if.sv
// TRI request/response channel. Handshake: the master holds req_valid and
// the request fields stable until the slave returns req_ack in that cycle;
// resp_val is a single-cycle strobe from slave to master, acknowledged by
// resp_ack in the same cycle.
interface tri_if;
    logic                               req_valid;
    tri_rr_sched_pkg::l15_reqtypes_t    req_type;
    logic [2:0]                         req_size;
    logic [39:0]                        req_addr;
    logic [63:0]                        req_data;
    logic [3:0]                         req_amo_op;
    logic                               req_ack;
    logic                               resp_val;
    tri_rr_sched_pkg::l15_rettypes_t    resp_type;
    logic [63:0]                        resp_data;
    logic                               resp_atomic;
    logic                               resp_inv_valid;
    logic [1:0]                         resp_inv_way;
    logic                               resp_ack;

    modport master (
        output req_valid, req_type, req_size, req_addr, req_data, req_amo_op, resp_ack,
        input  req_ack, resp_val, resp_type, resp_data, resp_atomic, resp_inv_valid, resp_inv_way
    );

    modport slave (
        input  req_valid, req_type, req_size, req_addr, req_data,
        output req_ack, resp_val, resp_type, resp_data, resp_atomic, resp_inv_valid, resp_inv_way
    );
endinterface

// File: rtl/tri_rr_sched_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so ptr is at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    // Rotate requests so that the current pointer position becomes bit 0.
    always_comb begin : p_rotate
        int j;
        rot = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            rot[k] = req_i[j[IW-1:0]];
        end
    end

    // Lowest set bit of the rotated vector, mapped back to a source index.
    always_comb begin : p_encode
        int j;
        valid_o = |req_i;
        off     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        j = int'(ptr_i) + int'(off);
        if (j >= N) j = j - N;
        idx_o = j[IW-1:0];
    end
endmodule

// File: rtl/tri_rr_sched.sv
// Shares one TRI sink among SOURCE_NUM requesters, one transaction at a
// time, in round-robin order. The scheduler forwards only the response
// that matches the granted request and abandons it after a watchdog.
module tri_rr_sched
    import tri_rr_sched_pkg::*;
#(
    parameter int SOURCE_NUM     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tri_if.slave                          tri_source [SOURCE_NUM],
    tri_if.master                         tri_sink,
    input  logic                          err_clr,
    output logic                          busy,
    output logic [$clog2(SOURCE_NUM)-1:0] grant_idx,
    output logic                          timeout_err,
    output logic                          unsupp_err,
    output state_t                        state_dbg
);
    localparam int IW   = $clog2(SOURCE_NUM);
    localparam int WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    l15_rettypes_t exp_type_q, exp_type_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic          unsupp_err_q, unsupp_err_d;

    logic          sink_req_valid;
    logic          ack_fwd;
    logic          resp_fwd;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    logic [SOURCE_NUM-1:0] src_valid;
    l15_reqtypes_t         src_type [SOURCE_NUM];
    logic [2:0]            src_size [SOURCE_NUM];
    logic [39:0]           src_addr [SOURCE_NUM];
    logic [63:0]           src_data [SOURCE_NUM];

    // Interface arrays only take constant indices, so flatten requests into
    // plain arrays and gate ack/resp_val per source against the grant.
    for (genvar g = 0; g < SOURCE_NUM; g++) begin : g_src
        assign src_valid[g] = tri_source[g].req_valid;
        assign src_type[g]  = tri_source[g].req_type;
        assign src_size[g]  = tri_source[g].req_size;
        assign src_addr[g]  = tri_source[g].req_addr;
        assign src_data[g]  = tri_source[g].req_data;

        assign tri_source[g].req_ack        = ack_fwd  && (grant_q == IW'(g));
        assign tri_source[g].resp_val       = resp_fwd && (grant_q == IW'(g));
        assign tri_source[g].resp_type      = tri_sink.resp_type;
        assign tri_source[g].resp_data      = tri_sink.resp_data;
        assign tri_source[g].resp_atomic    = tri_sink.resp_atomic;
        assign tri_source[g].resp_inv_valid = tri_sink.resp_inv_valid;
        assign tri_source[g].resp_inv_way   = tri_sink.resp_inv_way;
    end

    assign tri_sink.req_valid  = sink_req_valid;
    assign tri_sink.req_type   = src_type[grant_q];
    assign tri_sink.req_size   = src_size[grant_q];
    assign tri_sink.req_addr   = src_addr[grant_q];
    assign tri_sink.req_data   = src_data[grant_q];
    assign tri_sink.req_amo_op = '0;
    assign tri_sink.resp_ack   = tri_sink.resp_val;

    assign busy        = (state_q != S_IDLE);
    assign grant_idx   = grant_q;
    assign timeout_err = timeout_err_q;
    assign unsupp_err  = unsupp_err_q;
    assign state_dbg   = state_q;

    rr_picker #(.N(SOURCE_NUM)) u_picker (
        .req_i   (src_valid),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // State, grant latches, watchdog and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            exp_type_q    <= LOAD_RET;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            unsupp_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            exp_type_q    <= exp_type_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
            unsupp_err_q  <= unsupp_err_d;
        end
    end

    // Next-state and handshake decode; a set event overrides err_clr.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        exp_type_d     = exp_type_q;
        wd_cnt_d       = wd_cnt_q;
        timeout_err_d  = timeout_err_q & ~err_clr;
        unsupp_err_d   = unsupp_err_q & ~err_clr;
        sink_req_valid = 1'b0;
        ack_fwd        = 1'b0;
        resp_fwd       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    rr_ptr_d   = (pick_idx == IW'(SOURCE_NUM - 1)) ? '0 : pick_idx + 1'b1;
                    exp_type_d = exp_resp_type(src_type[pick_idx]);
                    state_d    = is_supported(src_type[pick_idx]) ? S_REQ : S_DROP;
                end
            end
            S_REQ: begin
                sink_req_valid = 1'b1;
                ack_fwd        = tri_sink.req_ack;
                if (tri_sink.req_ack) begin
                    state_d  = S_RESP;
                    wd_cnt_d = '0;
                end
            end
            S_RESP: begin
                if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
                if (tri_sink.resp_val && (tri_sink.resp_type == exp_type_q)) begin
                    resp_fwd = 1'b1;
                    state_d  = S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_DROP: begin
                ack_fwd      = 1'b1;
                unsupp_err_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tri_rr_sched.sv
// Bench for tri_rr_sched with 4 sources and a 16-cycle response watchdog.
module tb_tri_rr_sched;
  import tri_rr_sched_pkg::*;

  localparam int NS = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_err_clr = 1'b0;

  logic          tb_req_valid [NS];
  l15_reqtypes_t tb_req_type [NS];
  logic [39:0]   tb_addr [NS];
  logic [63:0]   tb_data [NS];

  logic          sk_req_ack = 1'b0;
  logic          sk_resp_val = 1'b0;
  l15_rettypes_t sk_resp_type = LOAD_RET;
  logic [63:0]   sk_resp_data = '0;

  logic        dut_req_ack [NS];
  logic        dut_resp_val [NS];
  logic [63:0] dut_resp_data [NS];
  logic        dut_busy, dut_terr, dut_uerr;
  logic [1:0]  dut_grant;
  state_t      dut_state;

  tri_if src_if [NS] ();
  tri_if sink_if ();

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_src
    assign src_if[g].req_valid  = tb_req_valid[g];
    assign src_if[g].req_type   = tb_req_type[g];
    assign src_if[g].req_size   = 3'd3;
    assign src_if[g].req_addr   = tb_addr[g];
    assign src_if[g].req_data   = tb_data[g];
    assign src_if[g].req_amo_op = 4'd0;
    assign src_if[g].resp_ack   = src_if[g].resp_val;
    assign dut_req_ack[g]       = src_if[g].req_ack;
    assign dut_resp_val[g]      = src_if[g].resp_val;
    assign dut_resp_data[g]     = src_if[g].resp_data;
  end

  assign sink_if.req_ack        = sk_req_ack;
  assign sink_if.resp_val       = sk_resp_val;
  assign sink_if.resp_type      = sk_resp_type;
  assign sink_if.resp_data      = sk_resp_data;
  assign sink_if.resp_atomic    = 1'b0;
  assign sink_if.resp_inv_valid = 1'b0;
  assign sink_if.resp_inv_way   = 2'd0;

  tri_rr_sched #(.SOURCE_NUM(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tri_source  (src_if),
    .tri_sink    (sink_if),
    .err_clr     (tb_err_clr),
    .busy        (dut_busy),
    .grant_idx   (dut_grant),
    .timeout_err (dut_terr),
    .unsupp_err  (dut_uerr),
    .state_dbg   (dut_state)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: a transaction view of the scheduler.
  // m_phase: 0 waiting for a grant, 1 request offered to sink,
  // 2 awaiting response, 3 unsupported request being refused.
  int            m_phase, m_grant, m_ptr, m_wd, resp_delay, sink_mode;
  bit            m_terr, m_uerr, m_new, late_resp, clr_in_drop;
  l15_rettypes_t m_exp;
  int            rem [NS];
  l15_reqtypes_t src_type [NS];
  int            resp_cnt [NS];
  int            ack_cnt [NS];
  int            sink_rv_cnt;
  logic [1:0]    obs_grants[$];
  logic [1:0]    exp_q[$];

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    tb_err_clr = 1'b0;
    sk_req_ack = 1'b0; sk_resp_val = 1'b0; sk_resp_type = LOAD_RET;
    for (int i = 0; i < NS; i++) begin
      rem[i] = 0; resp_cnt[i] = 0; ack_cnt[i] = 0;
      src_type[i] = LOAD_RQ;
      tb_req_valid[i] = 1'b0; tb_req_type[i] = LOAD_RQ;
      tb_addr[i] = {8'($urandom), $urandom};
      tb_data[i] = {$urandom, $urandom};
    end
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    m_phase = 0; m_grant = 0; m_ptr = 0; m_wd = 0; m_terr = 0; m_uerr = 0;
    m_new = 0; late_resp = 0; clr_in_drop = 0; sink_mode = 0; resp_delay = 0;
    m_exp = LOAD_RET; sink_rv_cnt = 0;
    obs_grants.delete();
    exp_q.delete();
  endtask

  // Drives sources and a responding sink cycle by cycle, checking every DUT
  // output against the model. Stops after n_done finished transactions, on
  // entering the response phase (stop_in_resp), or after max_cycles (fixed).
  task automatic run_engine(input int n_done, input int max_cycles,
                            input bit stop_in_resp, input bit fixed);
    int cyc, done, j;
    bit fin, resp_now, exp_ack, exp_rv, sup;
    cyc = 0; done = 0; fin = 0;
    while (!fin) begin
      @(posedge clk); #2;
      for (int i = 0; i < NS; i++) begin
        tb_req_valid[i] = (rem[i] > 0);
        tb_req_type[i] = src_type[i];
      end
      tb_err_clr = clr_in_drop && (m_phase == 3);
      sk_req_ack = 1'b0; sk_resp_val = 1'b0; sk_resp_type = LOAD_RET;
      sk_resp_data = {$urandom, $urandom};
      resp_now = 0;
      if (m_phase == 1) begin
        sk_req_ack = 1'($urandom_range(0, 1));
      end else if (m_phase == 2) begin
        if (sink_mode == 0 && m_wd == resp_delay) begin
          sk_resp_val = 1'b1; sk_resp_type = m_exp; resp_now = 1;
        end else if (sink_mode == 1 && m_wd == 0) begin
          sk_resp_val = 1'b1; sk_resp_type = (m_exp == LOAD_RET) ? ST_ACK : LOAD_RET;
        end else if (sink_mode == 1 && m_wd == 5) begin
          sk_resp_val = 1'b1; sk_resp_type = m_exp; resp_now = 1;
        end
      end else if (m_phase == 0 && late_resp) begin
        sk_resp_val = 1'b1; sk_resp_type = m_exp; late_resp = 0;
      end
      #2;
      n_tests++;
      if (dut_busy !== (m_phase != 0)) begin
        n_fail++; $display("FAIL busy: got %0b want %0b", dut_busy, (m_phase != 0));
      end
      n_tests++;
      if (dut_grant !== 2'(m_grant)) begin
        n_fail++; $display("FAIL grant_idx: got %0d want %0d", dut_grant, m_grant);
      end
      n_tests++;
      if (sink_if.req_valid !== (m_phase == 1)) begin
        n_fail++; $display("FAIL sink_req_valid: got %0b want %0b", sink_if.req_valid, (m_phase == 1));
      end
      if (m_phase == 1) begin
        n_tests++;
        if (sink_if.req_type !== src_type[m_grant] || sink_if.req_addr !== tb_addr[m_grant] ||
            sink_if.req_data !== tb_data[m_grant] || sink_if.req_amo_op !== 4'd0) begin
          n_fail++;
          $display("FAIL sink_req_mux: got type %0h addr %h want type %0h addr %h",
                   sink_if.req_type, sink_if.req_addr, src_type[m_grant], tb_addr[m_grant]);
        end
      end
      for (int i = 0; i < NS; i++) begin
        exp_ack = (i == m_grant) && ((m_phase == 1 && sk_req_ack) || m_phase == 3);
        exp_rv = (i == m_grant) && resp_now;
        n_tests++;
        if (dut_req_ack[i] !== exp_ack || dut_resp_val[i] !== exp_rv) begin
          n_fail++;
          $display("FAIL src%0d_ack_resp: got ack %0b resp_val %0b want ack %0b resp_val %0b",
                   i, dut_req_ack[i], dut_resp_val[i], exp_ack, exp_rv);
        end
        if (dut_resp_val[i] === 1'b1) resp_cnt[i]++;
        if (dut_req_ack[i] === 1'b1) ack_cnt[i]++;
      end
      if (sink_if.req_valid === 1'b1) sink_rv_cnt++;
      n_tests++;
      if (sink_if.resp_ack !== sk_resp_val) begin
        n_fail++; $display("FAIL sink_resp_ack: got %0b want %0b", sink_if.resp_ack, sk_resp_val);
      end
      n_tests++;
      if (dut_terr !== m_terr || dut_uerr !== m_uerr) begin
        n_fail++;
        $display("FAIL sticky_errs: got timeout %0b unsupp %0b want timeout %0b unsupp %0b",
                 dut_terr, dut_uerr, m_terr, m_uerr);
      end
      if (resp_now) begin
        n_tests++;
        if (dut_resp_data[m_grant] !== sk_resp_data) begin
          n_fail++; $display("FAIL resp_data: got %h want %h", dut_resp_data[m_grant], sk_resp_data);
        end
      end
      if (m_new) begin
        obs_grants.push_back(dut_grant);
        m_new = 0;
      end
      // advance the model
      case (m_phase)
        0: begin
          for (int s = NS - 1; s >= 0; s--) begin
            j = (m_ptr + s) % NS;
            if (tb_req_valid[j]) m_grant = j;
          end
          if (tb_req_valid[0] || tb_req_valid[1] || tb_req_valid[2] || tb_req_valid[3]) begin
            m_ptr = (m_grant + 1) % NS;
            sup = (src_type[m_grant] == LOAD_RQ) || (src_type[m_grant] == STORE_RQ);
            m_exp = (src_type[m_grant] == STORE_RQ) ? ST_ACK : LOAD_RET;
            m_phase = sup ? 1 : 3;
            m_new = 1;
          end
        end
        1: if (sk_req_ack) begin
          rem[m_grant]--; m_phase = 2; m_wd = 0; resp_delay = $urandom_range(0, 3);
        end
        2: if (resp_now) begin
          m_phase = 0; done++;
        end else begin
          m_wd++;
          if (m_wd == TO) begin
            m_terr = 1; m_phase = 0; done++;
            late_resp = (sink_mode == 2);
          end
        end
        default: begin
          rem[m_grant]--; m_uerr = 1; m_phase = 0; done++;
        end
      endcase
      cyc++;
      if (fixed) fin = (cyc >= max_cycles);
      else if ((stop_in_resp && m_phase == 2) || (!stop_in_resp && done >= n_done)) fin = 1;
      else if (cyc >= max_cycles) begin
        n_tests++; n_fail++;
        $display("FAIL engine_budget: %0d cycles used, %0d of %0d transactions done", cyc, done, n_done);
        fin = 1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_tests++;
    if (dut_busy !== 1'b0 || dut_grant !== 2'd0 || dut_state !== S_IDLE) begin
      n_fail++; $display("FAIL reset_state: got busy %0b grant %0d want busy 0 grant 0", dut_busy, dut_grant);
    end
    n_tests++;
    if (dut_terr !== 1'b0 || dut_uerr !== 1'b0 || sink_if.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got timeout %0b unsupp %0b sink_rv %0b want 0 0 0",
                         dut_terr, dut_uerr, sink_if.req_valid);
    end
    for (int i = 0; i < NS; i++) begin
      n_tests++;
      if (dut_req_ack[i] !== 1'b0 || dut_resp_val[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_src%0d: got ack %0b resp_val %0b want 0 0", i, dut_req_ack[i], dut_resp_val[i]);
      end
    end
  endtask

  task automatic test_two_loads();
    do_reset();
    rem[0] = 1; rem[2] = 1;
    run_engine(2, 200, 0, 0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    n_tests++;
    if (obs_grants.size() != exp_q.size()) begin
      n_fail++; $display("FAIL two_loads_count: got %0d grants want %0d", obs_grants.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_tests++;
        if (obs_grants[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL two_loads_order[%0d]: got %0d want %0d", k, obs_grants[k], exp_q[k]);
        end
      end
    end
    n_tests++;
    if (resp_cnt[0] != 1 || resp_cnt[2] != 1 || resp_cnt[1] != 0 || resp_cnt[3] != 0) begin
      n_fail++; $display("FAIL two_loads_resp: got %0d %0d %0d %0d want 1 0 1 0",
                         resp_cnt[0], resp_cnt[1], resp_cnt[2], resp_cnt[3]);
    end
  endtask

  task automatic test_all_stores();
    do_reset();
    for (int i = 0; i < NS; i++) begin rem[i] = 2; src_type[i] = STORE_RQ; end
    run_engine(8, 400, 0, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back(2'(k % NS));
    n_tests++;
    if (obs_grants.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rr_count: got %0d grants want %0d", obs_grants.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_tests++;
        if (obs_grants[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, obs_grants[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_wrong_type();
    do_reset();
    rem[1] = 1; sink_mode = 1;
    run_engine(1, 200, 0, 0);
    n_tests++;
    if (resp_cnt[1] != 1) begin
      n_fail++; $display("FAIL wrong_type_resp: got %0d resp_val on src1 want 1", resp_cnt[1]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rem[0] = 1; sink_mode = 2;
    run_engine(1, 200, 0, 0);
    run_engine(0, 4, 0, 1);
    n_tests++;
    if (resp_cnt[0] != 0 || dut_terr !== 1'b1 || dut_busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_end: got resp %0d timeout %0b busy %0b want 0 1 0",
                         resp_cnt[0], dut_terr, dut_busy);
    end
    @(posedge clk); #2;
    tb_err_clr = 1'b1; sk_resp_val = 1'b0;
    @(posedge clk); #2;
    tb_err_clr = 1'b0;
    #2;
    n_tests++;
    if (dut_terr !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got %0b want 0", dut_terr);
    end
    m_terr = 0;
  endtask

  task automatic test_unsupported();
    do_reset();
    rem[3] = 1; src_type[3] = IMISS_RQ; clr_in_drop = 1;
    run_engine(1, 100, 0, 0);
    clr_in_drop = 0;
    run_engine(0, 2, 0, 1);
    n_tests++;
    if (ack_cnt[3] != 1 || sink_rv_cnt != 0 || dut_uerr !== 1'b1) begin
      n_fail++; $display("FAIL unsupported: got ack %0d sink_rv %0d unsupp %0b want 1 0 1",
                         ack_cnt[3], sink_rv_cnt, dut_uerr);
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    rem[2] = 1; sink_mode = 2;
    run_engine(0, 100, 1, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) begin rem[i] = 0; tb_req_valid[i] = 1'b0; end
    sk_req_ack = 1'b0; sk_resp_val = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    sk_resp_val = 1'b1; sk_resp_type = LOAD_RET;
    #2;
    n_tests++;
    if (dut_busy !== 1'b0 || dut_grant !== 2'd0) begin
      n_fail++; $display("FAIL reset_in_resp: got busy %0b grant %0d want 0 0", dut_busy, dut_grant);
    end
    n_tests++;
    if (dut_resp_val[0] !== 1'b0 || dut_resp_val[1] !== 1'b0 ||
        dut_resp_val[2] !== 1'b0 || dut_resp_val[3] !== 1'b0) begin
      n_fail++; $display("FAIL reset_late_resp: got resp_val %0b%0b%0b%0b want 0000",
                         dut_resp_val[3], dut_resp_val[2], dut_resp_val[1], dut_resp_val[0]);
    end
    @(posedge clk); #2;
    sk_resp_val = 1'b0;
  endtask

  task automatic test_random_traffic();
    int total, r;
    do_reset();
    for (int round = 0; round < 4; round++) begin
      total = 0;
      for (int i = 0; i < NS; i++) begin
        rem[i] = $urandom_range(0, 3);
        r = $urandom_range(0, 7);
        src_type[i] = (r < 3) ? LOAD_RQ : (r < 6) ? STORE_RQ : (r == 6) ? IMISS_RQ : CAS1_RQ;
        total += rem[i];
      end
      if (total == 0) begin rem[0] = 1; total = 1; end
      run_engine(total, 600, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_two_loads();
    test_all_stores();
    test_wrong_type();
    test_timeout();
    test_unsupported();
    test_reset_in_resp();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
